// File: rtl/keyboard_pkg.sv
// Shared constants, register map and FSM encoding for the keypad event queue.
// KEYBOARD_TIMESTAMP_EN (see keyboard_ahb_fifo) widens FIFO entries by TS_W.
package keyboard_pkg;

  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned TS_W       = 16;

  // Register offsets as decoded from HADDR[3:2]
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_FLAGS  = 2'd3;

  localparam int unsigned DATA_VALID_BIT = 8;
  localparam int unsigned DATA_TS_LSB    = 16;
  localparam int unsigned ST_EMPTY_BIT   = 16;
  localparam int unsigned ST_FULL_BIT    = 17;
  localparam int unsigned ST_OVF_BIT     = 18;
  localparam int unsigned ST_STATE_LSB   = 19;

  typedef enum logic [1:0] {
    KB_IDLE  = 2'd0,
    KB_CLEAR = 2'd1,
    KB_DRAIN = 2'd2
  } kb_state_e;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [15:0] bits);
    lowest_set = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (bits[i-1]) lowest_set = KEY_CODE_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/keyboard_ahb_fifo_if.sv
// AHB-Lite slave-side signal bundle for the keypad event queue.
interface keyboard_ahb_fifo_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/keyboard_fifo.sv
// Synchronous FIFO with push/pop/flush; flush overrides both push and pop.
module keyboard_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_set
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only if a pop frees the slot this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & ~do_push & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keyboard_ahb_fifo.sv
// Keypad bitmap capture -> key-code FIFO, read by the CPU over AHB-Lite.
// Define KEYBOARD_TIMESTAMP_EN to tag each entry with a 16-bit snapshot time.
module keyboard_ahb_fifo
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [15:0]         key_data,
  input  logic                key_interrupt,
  output logic                key_clear,
  keyboard_ahb_fifo_if.slave  ahb,
  output logic                key_irq
);
`ifdef KEYBOARD_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = KEY_CODE_W + TS_W;
`else
  localparam int unsigned ENTRY_W = KEY_CODE_W;
`endif
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  kb_state_e              state_q, state_d;
  logic [15:0]            shadow_q, shadow_d;
  logic                   irq_en_q, irq_en_d;
  logic                   ovf_q, ovf_d;
  logic                   key_irq_q, key_irq_d;
  logic                   dphase_q, dphase_d;
  logic                   dwrite_q, dwrite_d;
  logic [1:0]             daddr_q, daddr_d;

  logic                   push, pop, flush, rd, wr;
  logic [KEY_CODE_W-1:0]  code;
  logic [ENTRY_W-1:0]     fifo_wdata, fifo_rdata;
  logic                   fifo_full, fifo_empty, ovf_set;
  logic [FCW-1:0]         fifo_count;
  logic [TS_W-1:0]        head_ts;
  logic [31:0]            hrdata;
  logic                   unused_ok;

  assign unused_ok = ^{key_interrupt, ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                       ahb.HWDATA[31:2]};

`ifdef KEYBOARD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] snap_ts_q, snap_ts_d;

  always_comb begin
    ts_cnt_d  = ts_cnt_q + TS_W'(1);
    snap_ts_d = (state_q == KB_IDLE && key_data != '0) ? ts_cnt_q : snap_ts_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_q  <= '0;
      snap_ts_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      snap_ts_q <= snap_ts_d;
    end
  end

  assign fifo_wdata = {snap_ts_q, code};
  assign head_ts    = fifo_rdata[ENTRY_W-1:KEY_CODE_W];
`else
  assign fifo_wdata = code;
  assign head_ts    = '0;
`endif

  // Capture FSM: snapshot, pulse the keypad clear, then emit one code per cycle.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    push      = 1'b0;
    key_clear = 1'b0;
    code      = lowest_set(shadow_q);
    case (state_q)
      KB_IDLE: begin
        if (key_data != '0) begin
          shadow_d = key_data;
          state_d  = KB_CLEAR;
        end
      end
      KB_CLEAR: begin
        key_clear = 1'b1;
        state_d   = KB_DRAIN;
      end
      KB_DRAIN: begin
        push     = 1'b1;
        shadow_d = shadow_q & (shadow_q - 16'd1);
        if (shadow_d == '0) state_d = KB_IDLE;
      end
      default: state_d = KB_IDLE;
    endcase
  end

  // AHB control: address phase is captured for use in the following data phase.
  always_comb begin
    dphase_d = dphase_q;
    dwrite_d = dwrite_q;
    daddr_d  = daddr_q;
    if (ahb.HREADY) begin
      dphase_d = ahb.HSEL & ahb.HTRANS[1];
      dwrite_d = ahb.HWRITE;
      daddr_d  = ahb.HADDR[3:2];
    end
  end

  assign rd    = dphase_q & ~dwrite_q;
  assign wr    = dphase_q & dwrite_q;
  assign pop   = rd & (daddr_q == ADDR_DATA);
  assign flush = wr & (daddr_q == ADDR_CTRL) & ahb.HWDATA[1];

  always_comb begin
    irq_en_d  = (wr && daddr_q == ADDR_CTRL) ? ahb.HWDATA[0] : irq_en_q;
    ovf_d     = ovf_set | (ovf_q & ~(wr & (daddr_q == ADDR_FLAGS) & ahb.HWDATA[0]));
    key_irq_d = irq_en_q & ~fifo_empty;
  end

  always_comb begin
    hrdata = '0;
    if (rd) begin
      case (daddr_q)
        ADDR_DATA: begin
          if (!fifo_empty) begin
            hrdata[KEY_CODE_W-1:0]       = fifo_rdata[KEY_CODE_W-1:0];
            hrdata[DATA_VALID_BIT]       = 1'b1;
            hrdata[DATA_TS_LSB +: TS_W]  = head_ts;
          end
        end
        ADDR_STATUS: begin
          hrdata[CNT_W-1:0]          = CNT_W'(fifo_count);
          hrdata[ST_EMPTY_BIT]       = fifo_empty;
          hrdata[ST_FULL_BIT]        = fifo_full;
          hrdata[ST_OVF_BIT]         = ovf_q;
          hrdata[ST_STATE_LSB +: 2]  = state_q;
        end
        ADDR_CTRL:  hrdata[0] = irq_en_q;
        ADDR_FLAGS: hrdata[0] = ovf_q;
        default:    hrdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = hrdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign key_irq       = key_irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= KB_IDLE;
      shadow_q  <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      key_irq_q <= 1'b0;
      dphase_q  <= 1'b0;
      dwrite_q  <= 1'b0;
      daddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      key_irq_q <= key_irq_d;
      dphase_q  <= dphase_d;
      dwrite_q  <= dwrite_d;
      daddr_q   <= daddr_d;
    end
  end

  keyboard_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (fifo_wdata),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .ovf_set (ovf_set)
  );

endmodule

// File: tb/tb_keyboard_ahb_fifo.sv
// Directed bench for keyboard_ahb_fifo (default build, FIFO_DEPTH=8).
module tb_keyboard_ahb_fifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] key_data = '0;
  logic        key_interrupt = 1'b0;
  logic        key_clear;
  logic        key_irq;
  int          tests = 0;
  int          fails = 0;

  keyboard_ahb_fifo_if bus ();

  keyboard_ahb_fifo #(
    .FIFO_DEPTH (8),
    .CNT_W      (6)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .key_data      (key_data),
    .key_interrupt (key_interrupt),
    .key_clear     (key_clear),
    .ahb           (bus),
    .key_irq       (key_irq)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8, A_FLAGS = 4'hC;

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, addr};
    @(posedge clk); #1;
    data = bus.HRDATA;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {28'h0, addr};
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    @(posedge clk); #1;
  endtask

  // Present a bitmap, wait (bounded) for the clear pulse, then let n codes drain.
  task automatic press(input logic [15:0] keys, input int n, output bit seen);
    seen = 1'b0;
    key_data = keys;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (key_clear) seen = 1'b1;
    end
    key_data = '0;
    if (!seen) begin
      fails++;
      $display("FAIL press_timeout keys=%h: key_clear never seen, required within 8 cycles", keys);
    end
    repeat (n + 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tests++;
    if (bus.HRDATA !== 32'h0 || key_clear !== 1'b0 || key_irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: hrdata=%h key_clear=%b key_irq=%b, required 0/0/0",
               bus.HRDATA, key_clear, key_irq);
    end
    tests++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus_resp: hreadyout=%b hresp=%b, required 1/0", bus.HREADYOUT, bus.HRESP);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0001_0000) begin
      fails++;
      $display("FAIL reset_status: got %h, required %h", d, 32'h0001_0000);
    end
  endtask

  task automatic test_single_key();
    logic [31:0] d;
    int cyc;
    ahb_write(A_CTRL, 32'h1);
    key_data = 16'h0010;
    cyc = 0;
    while (cyc < 8 && key_clear !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL single_clear_latency: key_clear after %0d cycles, required 1", cyc);
    end
    key_data = '0;
    @(posedge clk); #1;
    tests++;
    if (key_clear !== 1'b0) begin
      fails++;
      $display("FAIL single_clear_width: key_clear=%b in 2nd cycle, required 0", key_clear);
    end
    @(posedge clk); #1;
    tests++;
    if (key_irq !== 1'b0) begin
      fails++;
      $display("FAIL single_irq_early: key_irq=%b on push cycle, required 0", key_irq);
    end
    @(posedge clk); #1;
    tests++;
    if (key_irq !== 1'b1) begin
      fails++;
      $display("FAIL single_irq_rise: key_irq=%b, required 1", key_irq);
    end
    ahb_read(A_DATA, d);
    tests++;
    if (d !== 32'h0000_0104) begin
      fails++;
      $display("FAIL single_data: got %h, required %h", d, 32'h104);
    end
    @(posedge clk); #1;
    tests++;
    if (key_irq !== 1'b1) begin
      fails++;
      $display("FAIL single_irq_hold: key_irq=%b one cycle after pop, required 1", key_irq);
    end
    @(posedge clk); #1;
    tests++;
    if (key_irq !== 1'b0) begin
      fails++;
      $display("FAIL single_irq_fall: key_irq=%b, required 0", key_irq);
    end
  endtask

  task automatic test_multi_key();
    logic [31:0] d;
    logic [31:0] exp_st [4];
    logic [31:0] exp_dt [3];
    bit seen;
    exp_st[0] = 32'h0011_0000; exp_st[1] = 32'h0010_0001;
    exp_st[2] = 32'h0010_0002; exp_st[3] = 32'h0000_0003;
    exp_dt[0] = 32'h100; exp_dt[1] = 32'h10A; exp_dt[2] = 32'h10F;
    key_data = 16'h8401;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (key_clear) seen = 1'b1;
    end
    key_data = '0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL multi_clear: key_clear not seen, required a pulse");
    end
    for (int i = 0; i < 4; i++) begin
      ahb_read(A_STATUS, d);
      tests++;
      if (d !== exp_st[i]) begin
        fails++;
        $display("FAIL multi_status%0d: got %h, required %h", i, d, exp_st[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      ahb_read(A_DATA, d);
      tests++;
      if (d !== exp_dt[i]) begin
        fails++;
        $display("FAIL multi_data%0d: got %h, required %h", i, d, exp_dt[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bit seen;
    for (int i = 0; i < 9; i++) begin
      press(16'h1 << i, 1, seen);
    end
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0006_0008) begin
      fails++;
      $display("FAIL ovf_status: got %h, required %h", d, 32'h0006_0008);
    end
    ahb_read(A_FLAGS, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL ovf_flags: got %h, required %h", d, 32'h1);
    end
    ahb_write(A_FLAGS, 32'h1);
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0002_0008) begin
      fails++;
      $display("FAIL ovf_cleared_status: got %h, required %h", d, 32'h0002_0008);
    end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] d;
    bit seen;
    key_data = 16'h0800;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (key_clear) seen = 1'b1;
    end
    key_data = '0;
    ahb_read(A_DATA, d);   // data phase lines up with the DRAIN push
    tests++;
    if (!seen || d !== 32'h100) begin
      fails++;
      $display("FAIL full_pop_data: seen=%b got %h, required 1 / %h", seen, d, 32'h100);
    end
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0002_0008) begin
      fails++;
      $display("FAIL full_pop_status: got %h, required %h", d, 32'h0002_0008);
    end
    ahb_read(A_DATA, d);
    tests++;
    if (d !== 32'h101) begin
      fails++;
      $display("FAIL full_pop_next: got %h, required %h", d, 32'h101);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_empty();
    logic [31:0] d;
    ahb_write(A_CTRL, 32'h2);
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0001_0000) begin
      fails++;
      $display("FAIL flush_status: got %h, required %h", d, 32'h0001_0000);
    end
    ahb_read(A_DATA, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL empty_data: got %h, required %h", d, 32'h0);
    end
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0001_0000) begin
      fails++;
      $display("FAIL empty_no_underflow: got %h, required %h", d, 32'h0001_0000);
    end
    ahb_read(A_CTRL, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL ctrl_readback: got %h, required %h", d, 32'h0);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    bit seen;
    ahb_write(A_CTRL, 32'h1);
    press(16'h0020, 1, seen);
    @(posedge clk); #1;
    tests++;
    if (key_irq !== 1'b1) begin
      fails++;
      $display("FAIL mid_irq_before: key_irq=%b, required 1", key_irq);
    end
    key_data = 16'h0007;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (key_clear) seen = 1'b1;
    end
    key_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;    // one code pushed, two bits left in the shadow
    rstn = 1'b0;
    #1;
    tests++;
    if (!seen || key_clear !== 1'b0 || key_irq !== 1'b0 || bus.HRDATA !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: seen=%b key_clear=%b key_irq=%b hrdata=%h, required 1/0/0/0",
               seen, key_clear, key_irq, bus.HRDATA);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    ahb_read(A_STATUS, d);
    tests++;
    if (d !== 32'h0001_0000) begin
      fails++;
      $display("FAIL mid_reset_status: got %h, required %h", d, 32'h0001_0000);
    end
    ahb_read(A_CTRL, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_ctrl: got %h, required %h", d, 32'h0);
    end
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = '0; bus.HREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_key();
    test_multi_key();
    test_overflow();
    test_pop_push_full();
    test_flush_empty();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keyboard_ahb_fifo.md
Name: keyboard_ahb_fifo

Overview:
- Downstream consumer of the 4x4 keypad block's latched 16-bit key bitmap (`key_data`) and its `key_clear` input.
- Snapshots the bitmap, clears it, encodes each set bit into a 4-bit key code, and queues the codes in a small FIFO.
- The Cortex-M0 reads the FIFO and status over an AHB-Lite slave port; a level IRQ is raised while events are pending.

Parameters:
- FIFO_DEPTH, 8, number of queued key events; power of 2, range 2..32.
- CNT_W, 6, width of the STATUS count field; must be at least log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- key_data  in  16  latched key bitmap from keypad block; bit i = key i pressed
- key_interrupt  in  1  keypad press pulse (informational; capture keys on key_data != 0)
- key_clear  out  1  one-cycle pulse that clears the keypad bitmap
- HSEL  in  1  AHB slave select
- HADDR  in  32  AHB address; only [3:2] decoded
- HTRANS  in  2  AHB transfer type; bit1 = NONSEQ/SEQ
- HWRITE  in  1  AHB write
- HSIZE  in  3  ignored; word access assumed
- HWDATA  in  32  AHB write data
- HREADY  in  1  AHB bus ready
- HREADYOUT  out  1  constant 1 (zero wait state)
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data
- key_irq  out  1  level interrupt to NVIC

Behaviour:
- Reset (rstn low, async): FSM=IDLE, FIFO empty, overflow=0, irq_en=0. key_clear=0, key_irq=0, HRDATA=0.
- Capture FSM:
  - IDLE: if key_data != 0, latch shadow <= key_data; go to CLEAR.
  - CLEAR: key_clear=1 for exactly this cycle; go to DRAIN.
  - DRAIN: once per cycle, push the index of the lowest set shadow bit (4-bit code), then clear that bit. When shadow becomes 0, go to IDLE.
  - Snapshot to first push is 2 cycles. A 3-key snapshot takes 1+1+3 cycles to return to IDLE.
  - Presses arriving after the snapshot remain in the keypad bitmap and are captured on the next IDLE.
- FIFO rules:
  - Push when full: code dropped, overflow sticky flag set.
  - Push and pop in the same cycle: both happen, count unchanged; legal even when full.
  - Pop when empty: no state change; DATA returns valid=0.
  - Flush in the same cycle as a push: flush wins, the pushed code is lost. The capture FSM continues normally.
- AHB-Lite:
  - Address phase is sampled when HSEL & HTRANS[1] & HREADY; address and direction are registered for the data phase.
  - Reads: HRDATA is driven combinationally in the data phase from the registered address.
  - Writes: use HWDATA in the data phase.
- Register map (offset):
  - 0x0 DATA (RO, read pops):
    - [3:0] head code.
    - [8] valid (FIFO was non-empty).
    - Pop takes effect at the end of the data phase.
  - 0x4 STATUS (RO):
    - [CNT_W-1:0] count.
    - [16] empty, [17] full, [18] overflow.
    - [20:19] FSM state (IDLE=0, CLEAR=1, DRAIN=2).
  - 0x8 CTRL (RW):
    - [0] irq_en.
    - [1] flush: write 1 to empty the FIFO; self-clearing, reads 0.
  - 0xC FLAGS (W1C):
    - [0] clears overflow. Reads return overflow in bit 0.
- key_irq = irq_en & !empty, registered (one cycle after the count change).
- Unused read bits return 0. Writes to RO registers are ignored.

Optional Feature:
- Macro: KEYBOARD_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 0xFFFF.
  - The value at snapshot time is stored with every code pushed from that snapshot.
  - The FIFO entry is 20 bits wide; DATA[31:16] returns the head entry's timestamp.
- Undefined: no counter, 4-bit FIFO entries, DATA[31:16] reads 0.

Decomposition:
- Package keyboard_pkg:
  - register offsets ADDR_DATA/STATUS/CTRL/FLAGS;
  - KEY_CODE_W=4;
  - FSM state encoding;
  - STATUS bit positions;
  - timestamp width 16.
- Sub-module keyboard_fifo: synchronous FIFO with push/pop/flush, full/empty/count, width parameter; one instance.

Test Plan:
- key_data=0x0010 for 1 cycle, then 0 after key_clear -> key_clear pulses once; FIFO receives code 4. With irq_en=1, key_irq rises. DATA read returns 0x104, then key_irq falls.
- key_data=0x8401 -> codes 0,10,15 pushed in that order over 3 consecutive DRAIN cycles; STATUS count=3.
- 9 single-key snapshots with FIFO_DEPTH=8 -> count=8, full=1, overflow=1. Write FLAGS=1 -> overflow=0; count stays 8.
- DATA read with FIFO empty -> HRDATA=0x000 (valid=0); count stays 0; no underflow.
- DATA read pop in the same cycle as a DRAIN push while full -> count stays 8; the next DATA read returns the second-oldest code.
- rstn asserted mid-DRAIN with 2 bits remaining in shadow -> FSM=IDLE, FIFO empty, key_clear=0, key_irq=0 immediately.
